led_afterglow_pwm: RTL and testbench

//  - Downstream LED driver stage for the one-hot scanning pattern generator.
//  - Sampled one-hot positions set that channel to full brightness; brightness then decays

---
 rtl/led_afterglow_pwm.sv | 106 ++++++++++
 tb/tb_led_afterglow_pwm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_afterglow_pwm.sv
// Per-channel LED PWM driver with stepwise brightness decay ("comet tail" afterglow).
// Optional macro GAMMA_CORR_EN selects a gamma~2 duty curve instead of linear.
module led_afterglow_pwm #(
   parameter int N         = 8,
   parameter int BW        = 4,
   parameter int DECAY_DIV = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step_en,
   input  logic [N-1:0] led_in,
   output logic [N-1:0] pwm_out,
   output logic         onehot_err
);

   localparam int DW = $clog2(DECAY_DIV + 1);
   localparam logic [BW-1:0] MAX        = {BW{1'b1}};
   localparam logic [BW-1:0] CNT_LAST   = {{(BW-1){1'b1}}, 1'b0};
   localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);

   // Brightness level to PWM compare threshold.
   function automatic logic [BW-1:0] cmp(input logic [BW-1:0] lvl);
`ifdef GAMMA_CORR_EN
      logic [2*BW-1:0] sq;
      sq = ({{BW{1'b0}}, lvl} * {{BW{1'b0}}, lvl}) + {{BW{1'b0}}, MAX};
      return sq[2*BW-1:BW];
`else
      return lvl;
`endif
   endfunction

   logic [BW-1:0]         pwm_cnt_q, pwm_cnt_d;
   logic [DW-1:0]         decay_cnt_q, decay_cnt_d;
   logic [N-1:0][BW-1:0]  level_q, level_d;
   logic [N-1:0][BW-1:0]  shadow_q, shadow_d;
   logic [N-1:0]          pwm_out_q, pwm_out_d;
   logic                  onehot_err_q, onehot_err_d;
   logic                  period_end_s;
   logic                  decay_tick_s;
   logic [N-1:0]          led_dec_s;

   // Next-state logic: period/decay counters, levels, shadow thresholds, PWM and error flag.
   always_comb begin
      period_end_s = (pwm_cnt_q == CNT_LAST);
      decay_tick_s = period_end_s && (decay_cnt_q == DECAY_LAST);

      if (period_end_s) begin
         pwm_cnt_d = {BW{1'b0}};
      end else begin
         pwm_cnt_d = pwm_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      end

      if (decay_tick_s) begin
         decay_cnt_d = {DW{1'b0}};
      end else if (period_end_s) begin
         decay_cnt_d = decay_cnt_q + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         decay_cnt_d = decay_cnt_q;
      end

      // A fresh load beats a coincident decay so the head of the comet is always full.
      for (int i = 0; i < N; i++) begin
         if (step_en && led_in[i]) begin
            level_d[i] = MAX;
         end else if (decay_tick_s && (level_q[i] != {BW{1'b0}})) begin
            level_d[i] = level_q[i] - {{(BW-1){1'b0}}, 1'b1};
         end else begin
            level_d[i] = level_q[i];
         end

         if (period_end_s) begin
            shadow_d[i] = cmp(level_d[i]);
         end else begin
            shadow_d[i] = shadow_q[i];
         end

         pwm_out_d[i] = (pwm_cnt_d < shadow_d[i]);
      end

      led_dec_s    = led_in - {{(N-1){1'b0}}, 1'b1};
      onehot_err_d = step_en && ((led_in == {N{1'b0}}) || ((led_in & led_dec_s) != {N{1'b0}}));
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q    <= {BW{1'b0}};
         decay_cnt_q  <= {DW{1'b0}};
         level_q      <= {(N*BW){1'b0}};
         shadow_q     <= {(N*BW){1'b0}};
         pwm_out_q    <= {N{1'b0}};
         onehot_err_q <= 1'b0;
      end else begin
         pwm_cnt_q    <= pwm_cnt_d;
         decay_cnt_q  <= decay_cnt_d;
         level_q      <= level_d;
         shadow_q     <= shadow_d;
         pwm_out_q    <= pwm_out_d;
         onehot_err_q <= onehot_err_d;
      end
   end

   assign pwm_out    = pwm_out_q;
   assign onehot_err = onehot_err_q;

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Directed self-checking bench for led_afterglow_pwm (N=8, BW=4, DECAY_DIV=2).
module tb_led_afterglow_pwm;

   localparam int N  = 8;
   localparam int BW = 4;
   localparam int DD = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         step_en = 1'b0;
   logic [N-1:0] led_in = 8'h00;
   logic [N-1:0] pwm_out;
   logic         onehot_err;

   int total = 0;
   int bad   = 0;
   int e;
   int hi_cnt [N];

   led_afterglow_pwm #(.N(N), .BW(BW), .DECAY_DIV(DD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_en    (step_en),
      .led_in     (led_in),
      .pwm_out    (pwm_out),
      .onehot_err (onehot_err)
   );

   always #5 clk = ~clk;

   // Edges since reset release; e mod 15 equals the PWM phase.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) e <= 0;
      else        e <= e + 1;
   end

   function automatic int exp_duty(input int l);
`ifdef GAMMA_CORR_EN
      return (l * l + 15) >> 4;
`else
      return l;
`endif
   endfunction

   task automatic apply_reset;
      rst_n = 1'b0; step_en = 1'b0; led_in = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic goto_edge(input int target);
      int guard = 0;
      while (e < target && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      total++;
      if (e !== target) begin
         bad++;
         $display("FAIL goto_edge: at edge %0d, required %0d", e, target);
      end
   endtask

   task automatic drive_step(input logic [N-1:0] v);
      step_en = 1'b1; led_in = v;
      @(posedge clk); #1;
      step_en = 1'b0; led_in = 8'h00;
   endtask

   task automatic measure_period;
      for (int c = 0; c < N; c++) hi_cnt[c] = 0;
      for (int i = 0; i < 15; i++) begin
         for (int c = 0; c < N; c++) if (pwm_out[c] === 1'b1) hi_cnt[c]++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      total++;
      if (pwm_out !== 8'h00 || onehot_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: pwm=%h err=%b, required 00/0", pwm_out, onehot_err);
      end
      apply_reset();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         total++;
         if (pwm_out !== 8'h00 || onehot_err !== 1'b0) begin
            bad++;
            $display("FAIL idle_cycle%0d: pwm=%h err=%b, required 00/0", i, pwm_out, onehot_err);
         end
      end
   endtask

   task automatic test_single_decay;
      int starts [7] = '{15, 30, 60, 210, 420, 450, 480};
      int levels [7] = '{15, 14, 13, 8, 1, 0, 0};
      apply_reset();
      drive_step(8'h01);
      total++;
      if (onehot_err !== 1'b0) begin
         bad++;
         $display("FAIL valid_onehot_err: got %b, required 0", onehot_err);
      end
      total++;
      if (pwm_out !== 8'h00) begin
         bad++;
         $display("FAIL before_first_period: pwm=%h, required 00", pwm_out);
      end
      for (int k = 0; k < 7; k++) begin
         goto_edge(starts[k]);
         measure_period();
         total++;
         if (hi_cnt[0] !== exp_duty(levels[k])) begin
            bad++;
            $display("FAIL decay_duty@%0d: ch0 high %0d clks, required %0d",
                     starts[k], hi_cnt[0], exp_duty(levels[k]));
         end
         total++;
         if (hi_cnt[1] !== 0 || hi_cnt[7] !== 0) begin
            bad++;
            $display("FAIL idle_channels@%0d: ch1=%0d ch7=%0d, required 0", starts[k], hi_cnt[1], hi_cnt[7]);
         end
      end
   endtask

   task automatic test_stagger;
      int lv [3] = '{13, 14, 15};
      apply_reset();
      drive_step(8'h01);
      goto_edge(30);
      drive_step(8'h02);
      goto_edge(60);
      drive_step(8'h04);
      goto_edge(75);
      measure_period();
      for (int c = 0; c < 3; c++) begin
         total++;
         if (hi_cnt[c] !== exp_duty(lv[c])) begin
            bad++;
            $display("FAIL stagger_ch%0d: high %0d clks, required %0d", c, hi_cnt[c], exp_duty(lv[c]));
         end
      end
   endtask

   task automatic test_onehot;
      apply_reset();
      drive_step(8'h03);
      total++;
      if (onehot_err !== 1'b1) begin bad++; $display("FAIL err_multi: got %b, required 1", onehot_err); end
      step_en = 1'b1; led_in = 8'h00;
      @(posedge clk); #1;
      step_en = 1'b0;
      total++;
      if (onehot_err !== 1'b1) begin bad++; $display("FAIL err_zero: got %b, required 1", onehot_err); end
      @(posedge clk); #1;
      total++;
      if (onehot_err !== 1'b0) begin bad++; $display("FAIL err_not_sticky: got %b, required 0", onehot_err); end
      drive_step(8'h04);
      total++;
      if (onehot_err !== 1'b0) begin bad++; $display("FAIL err_valid: got %b, required 0", onehot_err); end
      goto_edge(15);
      measure_period();
      total++;
      if (hi_cnt[0] !== 15 || hi_cnt[1] !== 15 || hi_cnt[2] !== 15 || hi_cnt[3] !== 0) begin
         bad++;
         $display("FAIL multi_load: ch0..3 high %0d %0d %0d %0d, required 15 15 15 0",
                  hi_cnt[0], hi_cnt[1], hi_cnt[2], hi_cnt[3]);
      end
   endtask

   task automatic test_load_vs_decay;
      apply_reset();
      drive_step(8'h01);
      goto_edge(300);
      measure_period();
      total++;
      if (hi_cnt[0] !== exp_duty(5)) begin
         bad++; $display("FAIL level5: ch0 high %0d, required %0d", hi_cnt[0], exp_duty(5));
      end
      goto_edge(329);
      drive_step(8'h01);
      measure_period();
      total++;
      if (hi_cnt[0] !== exp_duty(15)) begin
         bad++; $display("FAIL load_beats_decay: ch0 high %0d, required %0d", hi_cnt[0], exp_duty(15));
      end
      goto_edge(360);
      measure_period();
      total++;
      if (hi_cnt[0] !== exp_duty(14)) begin
         bad++; $display("FAIL decay_after_reload: ch0 high %0d, required %0d", hi_cnt[0], exp_duty(14));
      end
   endtask

   task automatic test_async_reset;
      apply_reset();
      drive_step(8'h01);
      goto_edge(40);
      total++;
      if (pwm_out !== 8'h01) begin bad++; $display("FAIL mid_fade: pwm=%h, required 01", pwm_out); end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (pwm_out !== 8'h00 || onehot_err !== 1'b0) begin
         bad++; $display("FAIL async_clear: pwm=%h err=%b, required 00/0", pwm_out, onehot_err);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      goto_edge(15);
      measure_period();
      for (int c = 0; c < N; c++) begin
         total++;
         if (hi_cnt[c] !== 0) begin
            bad++; $display("FAIL after_reset_ch%0d: high %0d, required 0", c, hi_cnt[c]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_decay();
      test_stagger();
      test_onehot();
      test_load_vs_decay();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
